// File: rtl/m_mapping_pkg.sv
// Shared types and arithmetic for the Mitchell-fraction mapping pipeline.
// The map function is the single reference used by RTL and bench alike.
package m_mapping_pkg;

  localparam int MAXW  = 64;
  localparam int MAXSH = 8;

  typedef struct packed {
    logic             en;
    logic             neg;
    logic [MAXSH-1:0] sh;
    logic [MAXW-1:0]  off;
  } map_entry_t;

  function automatic logic [MAXW-1:0] wmask(int w);
    return (MAXW'(1) << w) - MAXW'(1);
  endfunction

  // Four-segment table matching the first-generation mapper.
  function automatic map_entry_t default_entry(
    int idx, int seg_bits, int wl_m, int ext
  );
    map_entry_t      e;
    logic [MAXW-1:0] m2;
    e  = '0;
    m2 = wmask(wl_m + ext);
    if (seg_bits == 2) begin
      case (idx)
        0: begin
          e.en  = 1'b1;
          e.sh  = MAXSH'(1);
          e.off = (MAXW'(1) << (wl_m + 1)) & m2;
        end
        2: begin
          e.en  = 1'b1;
          e.neg = 1'b1;
          e.off = (-(MAXW'(1) << wl_m)) & m2;
        end
        3: begin
          e.en  = 1'b1;
          e.neg = 1'b1;
          e.sh  = MAXSH'(1);
          e.off = (-(MAXW'(1) << (wl_m + 1))) & m2;
        end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  function automatic logic [MAXW-1:0] map_calc(
    logic [MAXW-1:0] m,
    map_entry_t      e,
    logic            map_en,
    int              ext,
    int              wl_m2
  );
    logic [MAXW-1:0] t;
    logic [MAXW-1:0] corr;
    logic [MAXW-1:0] r;
    t    = e.en ? (m << e.sh) : '0;
    corr = (e.neg ? -t : t) + e.off;
    r    = (m << ext) + (map_en ? corr : '0);
    return r & wmask(wl_m2);
  endfunction

endpackage

// File: rtl/m_mapping_table.sv
// Per-segment coefficient register file.
// Async reset to the default table, one write port, one comb read port.
module m_mapping_table
  import m_mapping_pkg::*;
#(
  parameter int WL_M     = 31,
  parameter int EXT      = 3,
  parameter int SEG_BITS = 2,
  parameter int SH_W     = 2,
  localparam int WL_M2   = WL_M + EXT,
  localparam int EW      = 2 + SH_W + WL_M2,
  localparam int NSEG    = 1 << SEG_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [SEG_BITS-1:0] waddr_i,
  input  logic [EW-1:0]       wdata_i,
  input  logic [SEG_BITS-1:0] raddr_i,
  output logic [EW-1:0]       rdata_o
);

  logic [EW-1:0] mem_q   [NSEG];
  logic [EW-1:0] rst_val [NSEG];

  for (genvar g = 0; g < NSEG; g++) begin : g_rst
    map_entry_t de;
    logic       unused_de;
    assign de = default_entry(g, SEG_BITS, WL_M, EXT);
    assign rst_val[g] = {
      de.en, de.neg, de.sh[SH_W-1:0], de.off[WL_M2-1:0]
    };
    assign unused_de = ^{de.sh[MAXSH-1:SH_W], de.off[MAXW-1:WL_M2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) mem_q[i] <= rst_val[i];
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/m_mapping_pipe.sv
// Two-stage Mitchell-fraction mapper: M2 = (M << EXT) + piecewise correction.
// Valid/ready handshake with full backpressure and a consumed-sample counter.
module m_mapping_pipe
  import m_mapping_pkg::*;
#(
  parameter int WL_M     = 31,
  parameter int EXT      = 3,
  parameter int SEG_BITS = 2,
  parameter int SH_W     = 2,
  parameter int CNT_W    = 16,
  localparam int WL_M2   = WL_M + EXT,
  localparam int EW      = 2 + SH_W + WL_M2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WL_M-1:0]     in_m,
  input  logic                in_map_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WL_M2-1:0]    out_m2,
  input  logic                cfg_we,
  input  logic [SEG_BITS-1:0] cfg_addr,
  input  logic [EW-1:0]       cfg_data,
  output logic [CNT_W-1:0]    sample_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic [WL_M-1:0]  s1_m_q, s1_m_d;
  logic             s1_en_q, s1_en_d;
  logic [EW-1:0]    s1_ent_q, s1_ent_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WL_M2-1:0] s2_m2_q, s2_m2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, s2_adv;
  logic             accept, consume;
  logic [EW-1:0]    lut_ent;
  map_entry_t       ge;
  logic [MAXW-1:0]  m_ext, m2_full;
  logic             unused_m2;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign consume  = s2_valid_q && out_ready;

  m_mapping_table #(
    .WL_M     (WL_M),
    .EXT      (EXT),
    .SEG_BITS (SEG_BITS),
    .SH_W     (SH_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (in_m[WL_M-1 -: SEG_BITS]),
    .rdata_o (lut_ent)
  );

  always_comb begin
    ge                  = '0;
    ge.en               = s1_ent_q[EW-1];
    ge.neg              = s1_ent_q[EW-2];
    ge.sh[SH_W-1:0]     = s1_ent_q[WL_M2 +: SH_W];
    ge.off[WL_M2-1:0]   = s1_ent_q[WL_M2-1:0];
    m_ext               = '0;
    m_ext[WL_M-1:0]     = s1_m_q;
    m2_full = map_calc(m_ext, ge, s1_en_q, EXT, WL_M2);
  end

  assign unused_m2 = ^m2_full[MAXW-1:WL_M2];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_m_d     = s1_m_q;
    s1_en_d    = s1_en_q;
    s1_ent_d   = s1_ent_q;
    s2_valid_d = s2_valid_q;
    s2_m2_d    = s2_m2_q;
    cnt_d      = cnt_q;
    // Stage 1 refills whenever it empties or moves forward.
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_m_d   = in_m;
      s1_en_d  = in_map_en;
      s1_ent_d = lut_ent;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_m2_d = m2_full[WL_M2-1:0];
    end
    if (consume) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_m_q     <= '0;
      s1_en_q    <= 1'b0;
      s1_ent_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_m2_q    <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_m_q     <= s1_m_d;
      s1_en_q    <= s1_en_d;
      s1_ent_q   <= s1_ent_d;
      s2_valid_q <= s2_valid_d;
      s2_m2_q    <= s2_m2_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_m2     = s2_m2_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_m_mapping_pipe.sv
// Directed bench for m_mapping_pipe: defaults, bypass, backpressure,
// table-write race, mid-stream reset and counter wrap.
module tb_m_mapping_pipe;
  import m_mapping_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] in_m = '0;
  logic        in_map_en = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [33:0] out_m2;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [37:0] cfg_data = '0;
  logic [15:0] sample_cnt;

  logic        unused_rdy4;
  logic        unused_vld4;
  logic [33:0] unused_m2_4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_mapping_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_m       (in_m),
    .in_map_en  (in_map_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_m2     (out_m2),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .sample_cnt (sample_cnt)
  );

  m_mapping_pipe #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (unused_rdy4),
    .in_m       (in_m),
    .in_map_en  (in_map_en),
    .out_valid  (unused_vld4),
    .out_ready  (out_ready),
    .out_m2     (unused_m2_4),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .sample_cnt (cnt4)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
  endtask

  function automatic logic [63:0] model(input logic [30:0] m,
                                        input logic en);
    logic [63:0] mx;
    mx = '0;
    mx[30:0] = m;
    return map_calc(mx, default_entry(int'(m[30:29]), 2, 31, 3),
                    en, 3, 34);
  endfunction

  logic [30:0] dm [4];
  logic [33:0] de [4];
  logic [30:0] rm [10];
  logic        ren [10];
  logic [63:0] q [$];
  logic [31:0] r;
  int          occ, sent, got, cyc;
  logic        acc, con, exp_rdy;

  initial begin
    dm[0] = 31'h00000000; de[0] = 34'h100000000;
    dm[1] = 31'h20000000; de[1] = 34'h100000000;
    dm[2] = 31'h40000000; de[2] = 34'h140000000;
    dm[3] = 31'h60000000; de[3] = 34'h140000000;

    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_m2", 64'(out_m2), 64'd0);
    check("rst_cnt", 64'(sample_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back defaults, out_ready high: output i after edge i+2.
    out_ready = 1'b1;
    in_map_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      if (i < 4) in_m = dm[i];
      step();
      if (i == 0) check("lat_early", 64'(out_valid), 64'd0);
      else begin
        check("def_valid", 64'(out_valid), 64'd1);
        check($sformatf("def_m2_%0d", i - 1), 64'(out_m2),
              64'(de[i-1]));
      end
    end
    in_valid = 1'b0;
    step();
    check("def_drain", 64'(out_valid), 64'd0);
    check("def_cnt", 64'(sample_cnt), 64'd4);

    in_valid  = 1'b1;
    in_map_en = 1'b0;
    in_m      = 31'h7FFFFFFF;
    step();
    in_valid  = 1'b0;
    step();
    check("bypass_m2", 64'(out_m2), 64'h3FFFFFFF8);
    in_map_en = 1'b1;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      r      = $urandom;
      rm[i]  = r[30:0];
      ren[i] = r[31];
    end
    occ = 0; sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      if (sent < 10) begin
        in_m      = rm[sent];
        in_map_en = ren[sent];
      end
      #1;
      exp_rdy = !(occ == 2 && !out_ready);
      check("bp_in_ready", 64'(in_ready), 64'(exp_rdy));
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
        if (q.size() == 0) check("bp_extra_out", 64'd1, 64'd0);
        else check("bp_m2", 64'(out_m2), q.pop_front());
      end
      if (acc) begin
        q.push_back(model(rm[sent], ren[sent]));
        sent++;
      end
      occ = occ + int'(acc) - int'(con);
      if (con) got++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_map_en = 1'b1;
    check("bp_all_out", 64'(got), 64'd10);
    check("bp_cnt", 64'(sample_cnt), 64'd10);

    // Write seg1 on the same edge a seg1 sample is accepted.
    cfg_we   = 1'b1;
    cfg_addr = 2'd1;
    cfg_data = {1'b1, 1'b0, 2'b00, 34'd5};
    in_valid = 1'b1;
    in_m     = 31'h20000000;
    step();
    cfg_we   = 1'b0;
    step();
    check("race_old", 64'(out_m2), 64'h100000000);
    in_valid = 1'b0;
    step();
    check("race_new", 64'(out_m2), 64'h120000005);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_m      = 31'h20000000;
    step();
    in_valid  = 1'b0;
    step();
    check("stall_valid", 64'(out_valid), 64'd1);
    step();
    check("stall_hold", 64'(out_m2), 64'h120000005);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_cnt", 64'(sample_cnt), 64'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_m      = 31'h20000000;
    step();
    in_valid  = 1'b0;
    step();
    check("midrst_seg1", 64'(out_m2), 64'h100000000);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_m     = 31'(i * 32'h01000003);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    check("wrap_cnt4", 64'(cnt4), 64'd1);
    check("wrap_cnt16", 64'(sample_cnt), 64'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_mapping_pipe.md
# m_mapping_pipe

Pipelined, parametrised successor of the Mitchell-fraction mapper. It takes a WL_M-bit Mitchell fraction M and produces a WL_M+EXT-bit mapped fraction M2 = (M << EXT) + correction. The correction is piecewise-linear over 2^SEG_BITS segments selected by the MSBs of M, and each segment's coefficients live in a run-time-writable table. It sits between the leading-one/Mitchell-fraction stage and the log-domain adder, and uses a valid/ready handshake with full backpressure.

## Interface
- WL_M, 31: Mitchell fraction width.
- EXT, 3: extra output bits; WL_M2 = WL_M+EXT.
- SEG_BITS, 2: segment-select bits; NSEG = 2^SEG_BITS.
- SH_W, 2: width of per-segment slope shift.
- CNT_W, 16: width of the sample counter.
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  sample accepted when in_valid&&in_ready.
- in_m  in  WL_M  Mitchell fraction M.
- in_map_en  in  1  1 = table correction, 0 = bypass (M2 = M<<EXT).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_m2  out  WL_M2  mapped fraction.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  SEG_BITS  segment index.
- cfg_data  in  2+SH_W+WL_M2  {en, neg, sh, off}.
- sample_cnt  out  CNT_W  count of results consumed (out_valid&&out_ready).

## Operation
- Segment index s = M[WL_M-1 -: SEG_BITS].
- Entry {en, neg, sh, off}: t = en ? (M<<sh) : 0; corr = (neg ? -t : t) + off. All arithmetic is modulo 2^WL_M2, with M zero-extended.
- Result: M2 = (M<<EXT) + (map_en ? corr : 0), truncated to WL_M2. There is no saturation.
- Reset table, SEG_BITS==2:
  - seg0 {1,0,1,2^(WL_M+1)}
  - seg1 {0,0,0,0}
  - seg2 {1,1,0,-2^WL_M}
  - seg3 {1,1,1,-2^(WL_M+1)}
  - With default parameters this is bit-exact with the first-generation mapper.
- Reset table, any other SEG_BITS: all entries zero (pure Mitchell shift).
- Table write: on cfg_we at edge k, the entry is updated at edge k. Samples accepted at edge k use the old entry. Samples accepted at edge k+1 or later use the new entry.
- Writes are accepted regardless of pipeline state. Samples already past stage 1 are unaffected.

## Timing
- Stage 1 (edge of accept): register M, map_en and the looked-up entry; s1_valid.
- Stage 2: register out_m2 computed from stage-1 contents; s2_valid = out_valid.
- Latency is 2 cycles from accept to out_valid with no stall. Throughput is 1 sample/cycle.
- Stall logic:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s2_adv.
  - in_ready = !s1_valid || s2_adv. This is a combinational path from out_ready.
- out_m2 and out_valid hold stable while out_valid && !out_ready.
- A simultaneous accept and consume with both stages full moves every stage forward with no bubble.
- sample_cnt increments on out_valid&&out_ready and wraps from 2^CNT_W-1 to 0.
- Reset values: out_valid=0, out_m2=0, sample_cnt=0, s1_valid=0, table = reset table. in_ready=1 while rst is deasserted and the pipeline is empty.
- Reset asserted mid-operation discards all in-flight samples immediately, including the one with out_valid high. Programmed table entries revert to reset values.

## Structure
- Package m_mapping_pkg holds:
  - the entry struct {en, neg, sh, off}
  - the function computing the default reset table from WL_M/EXT
  - a combinational map function (M, entry, map_en) -> M2, shared with the bench model.
- One sub-module, m_mapping_table: NSEG-entry register file with async reset, one write port and one combinational read port.
- The pipeline and counter live in m_mapping_pipe.

## Test plan
- Defaults after reset, map_en=1, out_ready=1:
  - M=0x00000000 -> 0x100000000
  - M=0x20000000 -> 0x100000000
  - M=0x40000000 -> 0x140000000
  - M=0x60000000 -> 0x140000000
  - Each output appears exactly 2 cycles after accept.
- Bypass: map_en=0, M=0x7FFFFFFF -> 0x3FFFFFFF8.
- Backpressure:
  - Stream 10 random samples with out_ready toggling pseudo-randomly.
  - Required: outputs match the package model in order, with no drops or duplicates.
  - Required: in_ready=0 only when both stages are full and out_ready=0.
  - Required: sample_cnt=10 at the end.
- Table write race:
  - At edge k write seg1={1,0,0,5} while accepting M=0x20000000; that sample -> 0x100000000.
  - The next M=0x20000000 -> 0x120000005.
- Reset mid-stream: assert rst with out_valid=1, out_ready=0 -> out_valid=0, sample_cnt=0, seg1 back to zero on the next post-reset sample.
- Counter wrap: with CNT_W=4, consume 17 samples -> sample_cnt=1.
